present_sbox_layer_ctrl: RTL and testbench
==========================================

Name: present_sbox_layer_ctrl

Overview:
- Sequences the 3-share, second-order masked PRESENT S-box pipeline over one full 64-bit cipher state.
- Streams 16 masked nibbles (3 shares each) into the S-box, one per enabled cycle, and collects results after the pipeline latency.
- Writes each result back into the same nibble position.
- Sits between the round-state register of the masked PRESENT core and the shared masked S-box instance. Drives the S-box global enable, which also gates its fresh-randomness consumption.

Parameters:
- LAT, 4, register stages in the masked S-box pipeline (enabled cycles from input to output); legal range 1..8.
- NNIB, 16, nibbles per state; fixed for PRESENT, range-checked in elaboration.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to process the loaded state; ignored while busy
- st_sh0_i / st_sh1_i / st_sh2_i  in  64 each  input state shares, sampled only on an accepted start
- rnd_vld  in  1  fresh randomness for the S-box is available this cycle
- sbox_en  out  1  advances the S-box pipeline and consumes randomness
- sbox_x0 / sbox_x1 / sbox_x2  out  4 each  input nibble shares to the S-box
- sbox_y0 / sbox_y1 / sbox_y2  in  4 each  output nibble shares from the S-box
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse: result valid
- st_sh0_o / st_sh1_o / st_sh2_o  out  64 each  result shares, held stable until the next accepted start

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, sbox_en=0, sbox_x*=0, st_sh*_o=0, all counters and the valid pipe cleared. Reset mid-operation aborts immediately; no partial result is flagged.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 loads the three 64-bit share registers, clears feed_cnt/cap_cnt/vpipe, goes to FEED.
- FEED: sbox_en = rnd_vld; sbox_x_k = share k nibble[feed_cnt] (bits 4i+3:4i, i = feed_cnt from 0 upward). On an enabled cycle: feed_cnt++, and a 1 is pushed into vpipe (LAT-deep valid shift register, advances only when sbox_en=1). Enabled cycle with feed_cnt=15 moves to DRAIN.
- DRAIN: sbox_en = rnd_vld; sbox_x*=0; a 0 is pushed into vpipe.
- Capture (FEED or DRAIN): when vpipe output=1 and sbox_en=1, sbox_y_k is written into share k nibble[cap_cnt] and cap_cnt++. Capture with cap_cnt=15 moves to DONE.
- The S-box pipeline freezes when sbox_en=0, so y is held across stalls. Never consume randomness without advancing vpipe.
- DONE: done=1 for exactly one cycle; st_sh*_o update in this same cycle; back to IDLE. busy=0 in DONE.
- Latency with rnd_vld=1 throughout: start seen at edge 0; FEED cycles 1..16; captures in cycles LAT+1..LAT+16; done in cycle LAT+17.
- Each rnd_vld=0 cycle during FEED/DRAIN adds exactly one cycle.
- start during FEED/DRAIN/DONE is ignored. start in the same cycle as reset: reset wins.
- Shares are never combined (XORed) anywhere in this block.

Optional Feature:
- RND_STALL_EN defined: sbox_en = rnd_vld in FEED/DRAIN, as above.
- RND_STALL_EN undefined: rnd_vld is ignored; sbox_en=1 throughout FEED/DRAIN, giving a fixed LAT+17 cycle latency. For use with a PRNG that is always valid.

Decomposition:
- Package present_mask_pkg: state enum (IDLE/FEED/DRAIN/DONE), NNIB, NIB_W=4, NSHARE=3, typedef for a 3-share nibble bundle.
- Sub-module nib_share_buf: a 3×64-bit share register with nibble read mux (feed index) and nibble write port (capture index). Instantiated once; handles load and writeback.

Test Plan:
- Unmasked vector: sh0=0x0123456789ABCDEF, sh1=sh2=0, rnd_vld=1, LAT=4, reference masked S-box model → done at cycle 21; sh0_o^sh1_o^sh2_o = 0xC56B90AD3EF84712.
- Random shares with the same XOR value, rnd_vld toggling 1,0,0,1… → same unmasked result; done delayed by exactly the number of rnd_vld=0 cycles in FEED/DRAIN; sbox_en never high when rnd_vld=0.
- start pulsed in cycle 5 and cycle LAT+17 (DONE) → both ignored; exactly one done pulse; outputs unchanged until the next IDLE start.
- rst_n=0 in cycle 10 of FEED → next cycle busy=0, sbox_en=0, outputs 0, no done. A fresh start then completes normally in LAT+17 cycles.
- Build without RND_STALL_EN, rnd_vld=0 constantly → sbox_en=1 for cycles 1..LAT+16; done at cycle LAT+17; result correct.
- Sweep LAT=1 and LAT=8 with the all-zero state (all shares 0) → unmasked output 0xCCCCCCCCCCCCCCCC; done at cycle 18 and 25 respectively.

Source files
------------

// File: rtl/present_mask_pkg.sv
// Shared constants and types for the masked PRESENT S-box layer controller.
package present_mask_pkg;
    localparam int NNIB    = 16;
    localparam int NIB_W   = 4;
    localparam int NSHARE  = 3;
    localparam int STATE_W = NNIB * NIB_W;
    localparam int IDX_W   = $clog2(NNIB);
    localparam int NIB_SH  = $clog2(NIB_W);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } layer_state_t;

    typedef logic [NIB_W-1:0]  nib_t;
    typedef nib_t [NSHARE-1:0] nib3_t;
endpackage

// File: rtl/nib_share_buf.sv
// Three 64-bit share registers with a nibble read mux and a nibble write-back port.
// o_nxt_sh* expose the contents including this cycle's pending write.
module nib_share_buf
    import present_mask_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [STATE_W-1:0] i_sh0,
    input  logic [STATE_W-1:0] i_sh1,
    input  logic [STATE_W-1:0] i_sh2,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output nib3_t              o_rd_nib,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  nib3_t              i_wr_nib,
    output logic [STATE_W-1:0] o_nxt_sh0,
    output logic [STATE_W-1:0] o_nxt_sh1,
    output logic [STATE_W-1:0] o_nxt_sh2
);
    logic [STATE_W-1:0]      r_sh  [NSHARE];
    logic [STATE_W-1:0]      w_nxt [NSHARE];
    logic [IDX_W+NIB_SH-1:0] w_rd_bit;
    logic [IDX_W+NIB_SH-1:0] w_wr_bit;

    assign w_rd_bit = {i_rd_idx, {NIB_SH{1'b0}}};
    assign w_wr_bit = {i_wr_idx, {NIB_SH{1'b0}}};

    always_comb begin
        for (int k = 0; k < NSHARE; k++) begin
            w_nxt[k] = r_sh[k];
            if (i_wr_en) begin
                w_nxt[k][w_wr_bit +: NIB_W] = i_wr_nib[k];
            end
            o_rd_nib[k] = r_sh[k][w_rd_bit +: NIB_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSHARE; k++) r_sh[k] <= '0;
        end else if (i_load) begin
            r_sh[0] <= i_sh0;
            r_sh[1] <= i_sh1;
            r_sh[2] <= i_sh2;
        end else begin
            for (int k = 0; k < NSHARE; k++) r_sh[k] <= w_nxt[k];
        end
    end

    assign o_nxt_sh0 = w_nxt[0];
    assign o_nxt_sh1 = w_nxt[1];
    assign o_nxt_sh2 = w_nxt[2];
endmodule

// File: rtl/present_sbox_layer_ctrl.sv
// Streams the 16 masked nibbles of a PRESENT state through the shared 3-share S-box and writes results back in place.
// Define RND_STALL_EN to let rnd_vld stall the S-box; otherwise it advances on every FEED/DRAIN cycle.
module present_sbox_layer_ctrl
    import present_mask_pkg::*;
#(
    parameter int LAT = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STATE_W-1:0] st_sh0_i,
    input  logic [STATE_W-1:0] st_sh1_i,
    input  logic [STATE_W-1:0] st_sh2_i,
    input  logic               rnd_vld,
    output logic               sbox_en,
    output logic [NIB_W-1:0]   sbox_x0,
    output logic [NIB_W-1:0]   sbox_x1,
    output logic [NIB_W-1:0]   sbox_x2,
    input  logic [NIB_W-1:0]   sbox_y0,
    input  logic [NIB_W-1:0]   sbox_y1,
    input  logic [NIB_W-1:0]   sbox_y2,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] st_sh0_o,
    output logic [STATE_W-1:0] st_sh1_o,
    output logic [STATE_W-1:0] st_sh2_o
);
    if (LAT < 1 || LAT > 8) begin : g_lat_check
        $error("present_sbox_layer_ctrl: LAT must be in 1..8");
    end
    if (NNIB != 16) begin : g_nnib_check
        $error("present_sbox_layer_ctrl: NNIB must be 16");
    end

    layer_state_t       r_state, w_next_state;
    logic [IDX_W-1:0]   r_feed_cnt, r_cap_cnt;
    logic [LAT-1:0]     r_vpipe;
    logic [STATE_W-1:0] r_out0, r_out1, r_out2;
    logic [STATE_W-1:0] w_nxt0, w_nxt1, w_nxt2;
    nib3_t              w_rd_nib, w_wr_nib;
    logic               w_rnd_ok, w_active, w_en, w_load;
    logic               w_feed_step, w_last_feed, w_capture, w_last_cap;

`ifdef RND_STALL_EN
    assign w_rnd_ok = rnd_vld;
`else
    logic w_unused_rnd;
    assign w_unused_rnd = rnd_vld;
    assign w_rnd_ok     = 1'b1;
`endif

    // The valid pipe and S-box share one enable, so randomness is never spent without tracking it.
    assign w_active    = (r_state == FEED) || (r_state == DRAIN);
    assign w_en        = w_active && w_rnd_ok;
    assign w_load      = (r_state == IDLE) && start;
    assign w_feed_step = (r_state == FEED) && w_en;
    assign w_last_feed = w_feed_step && (r_feed_cnt == IDX_W'(NNIB - 1));
    assign w_capture   = w_en && r_vpipe[LAT-1];
    assign w_last_cap  = w_capture && (r_cap_cnt == IDX_W'(NNIB - 1));
    assign w_wr_nib    = {sbox_y2, sbox_y1, sbox_y0};

    nib_share_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_sh0     (st_sh0_i),
        .i_sh1     (st_sh1_i),
        .i_sh2     (st_sh2_i),
        .i_rd_idx  (r_feed_cnt),
        .o_rd_nib  (w_rd_nib),
        .i_wr_en   (w_capture),
        .i_wr_idx  (r_cap_cnt),
        .i_wr_nib  (w_wr_nib),
        .o_nxt_sh0 (w_nxt0),
        .o_nxt_sh1 (w_nxt1),
        .o_nxt_sh2 (w_nxt2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_load)      w_next_state = FEED;
            FEED:    if (w_last_feed) w_next_state = DRAIN;
            DRAIN:   if (w_last_cap)  w_next_state = DONE;
            DONE:                     w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        sbox_en = 1'b0;
        sbox_x0 = '0;
        sbox_x1 = '0;
        sbox_x2 = '0;
        case (r_state)
            FEED: begin
                busy    = 1'b1;
                sbox_en = w_en;
                sbox_x0 = w_rd_nib[0];
                sbox_x1 = w_rd_nib[1];
                sbox_x2 = w_rd_nib[2];
            end
            DRAIN: begin
                busy    = 1'b1;
                sbox_en = w_en;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_load) begin
            r_feed_cnt <= '0;
            r_cap_cnt  <= '0;
            r_vpipe    <= '0;
        end else begin
            if (w_feed_step) r_feed_cnt <= r_feed_cnt + IDX_W'(1);
            if (w_capture)   r_cap_cnt  <= r_cap_cnt + IDX_W'(1);
            if (w_en)        r_vpipe    <= (r_vpipe << 1) | LAT'(r_state == FEED);
        end
    end

    // The final capture lands in DONE's cycle by latching the merged buffer contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
        end else if (w_last_cap) begin
            r_out0 <= w_nxt0;
            r_out1 <= w_nxt1;
            r_out2 <= w_nxt2;
        end
    end

    assign st_sh0_o = r_out0;
    assign st_sh1_o = r_out1;
    assign st_sh2_o = r_out2;
endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Scoreboard bench for present_sbox_layer_ctrl: three instances (LAT 4, 1, 8), each fed by a masked S-box model.
module tb_present_sbox_layer_ctrl;
    localparam int NDUT = 3;
    localparam int L0   = 4;

    typedef struct {
        int          dut;
        logic [63:0] val;
        int          doneCyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, start, rnd_vld;
    logic [63:0] shIn0, shIn1, shIn2;
    logic [NDUT-1:0] sboxEn, busyO, doneO;
    logic [3:0]  sboxX0 [NDUT];
    logic [3:0]  sboxX1 [NDUT];
    logic [3:0]  sboxX2 [NDUT];
    logic [63:0] shOut0 [NDUT];
    logic [63:0] shOut1 [NDUT];
    logic [63:0] shOut2 [NDUT];

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    logic [63:0] lastResult = 64'h0;

    always #5 clk = ~clk;

    function automatic int latOf(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
    endfunction

    function automatic logic [3:0] presentS(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] sboxLayer(input logic [63:0] x);
        logic [63:0] r = 64'h0;
        for (int i = 0; i < 16; i++) begin
            r = r | (64'(presentS(4'((x >> (4 * i)) & 64'hF))) << (4 * i));
        end
        return r;
    endfunction

    // Freshly remasked output: y0^y1^y2 = S(x0^x1^x2).
    function automatic logic [11:0] maskedSbox(input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] x2);
        logic [3:0] m1 = 4'($urandom);
        logic [3:0] m2 = 4'($urandom);
        return {presentS(x0 ^ x1 ^ x2) ^ m1 ^ m2, m1, m2};
    endfunction

    function automatic bit pat(input int n);
        return ((n - 1) % 3) == 0;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = latOf(g);
        logic [11:0] pipe [8];

        present_sbox_layer_ctrl #(.LAT(L)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .st_sh0_i (shIn0),
            .st_sh1_i (shIn1),
            .st_sh2_i (shIn2),
            .rnd_vld  (rnd_vld),
            .sbox_en  (sboxEn[g]),
            .sbox_x0  (sboxX0[g]),
            .sbox_x1  (sboxX1[g]),
            .sbox_x2  (sboxX2[g]),
            .sbox_y0  (pipe[L-1][11:8]),
            .sbox_y1  (pipe[L-1][7:4]),
            .sbox_y2  (pipe[L-1][3:0]),
            .busy     (busyO[g]),
            .done     (doneO[g]),
            .st_sh0_o (shOut0[g]),
            .st_sh1_o (shOut1[g]),
            .st_sh2_o (shOut2[g])
        );

        always @(posedge clk) begin
            if (sboxEn[g]) begin
                for (int k = 7; k > 0; k--) pipe[k] <= pipe[k-1];
                pipe[0] <= maskedSbox(sboxX0[g], sboxX1[g], sboxX2[g]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outXor(input int d);
        return shOut0[d] ^ shOut1[d] ^ shOut2[d];
    endfunction

    task automatic popFor(input int d, output exp_t e, output bit found);
        found = 1'b0;
        e = '{dut: -1, val: 64'h0, doneCyc: 0};
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].dut == d) begin
                e = sbq[i];
                sbq.delete(i);
                found = 1'b1;
                break;
            end
        end
    endtask

    // Pulses start for one edge and queues the expected result of each tracked instance.
    task automatic applyStimulus(input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] s2,
                                 input bit [NDUT-1:0] track, input int extra);
        exp_t e;
        shIn0 = s0;
        shIn1 = s1;
        shIn2 = s2;
        for (int d = 0; d < NDUT; d++) begin
            if (track[d]) begin
                e.dut     = d;
                e.val     = sboxLayer(s0 ^ s1 ^ s2);
                e.doneCyc = latOf(d) + 17 + extra;
                sbq.push_back(e);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        shIn0 = {$urandom, $urandom};
        shIn1 = {$urandom, $urandom};
        shIn2 = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_n = 1'b0; start = 1'b1; rnd_vld = 1'b1;
        shIn0 = 64'hFFFF_FFFF_FFFF_FFFF; shIn1 = 64'h0; shIn2 = 64'h0;
        repeat (3) tick();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if ({busyO[d], doneO[d], sboxEn[d]} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL reset_ctrl dut%0d got busy/done/en=%b want 000", d, {busyO[d], doneO[d], sboxEn[d]});
            end
            checks++;
            if ({sboxX0[d], sboxX1[d], sboxX2[d]} !== 12'h0) begin
                errors++;
                $display("[TB] FAIL reset_x dut%0d got %h want 000", d, {sboxX0[d], sboxX1[d], sboxX2[d]});
            end
            checks++;
            if ((shOut0[d] | shOut1[d] | shOut2[d]) !== 64'h0) begin
                errors++;
                $display("[TB] FAIL reset_out dut%0d got %h/%h/%h want 0", d, shOut0[d], shOut1[d], shOut2[d]);
            end
        end
        rst_n = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (busyO[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wins got busy=%b want 0", busyO[0]);
        end
    endtask

    task automatic test_unmasked();
        exp_t e; bit found; bit seen = 1'b0; int n = 1;
        $display("[TB] test_unmasked");
        rnd_vld = 1'b1;
        applyStimulus(64'h0123456789ABCDEF, 64'h0, 64'h0, 3'b001, 0);
        while (!seen && n <= 60) begin
            #1;
            if (doneO[0] === 1'b1) begin
                seen = 1'b1;
                popFor(0, e, found);
                checks++;
                if (!found || n != e.doneCyc) begin
                    errors++;
                    $display("[TB] FAIL unmasked_latency got cycle %0d want %0d", n, e.doneCyc);
                end
                checks++;
                if (outXor(0) !== 64'hC56B90AD3EF84712) begin
                    errors++;
                    $display("[TB] FAIL unmasked_value got %h want C56B90AD3EF84712", outXor(0));
                end
                checks++;
                if (busyO[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL unmasked_busy_in_done got %b want 0", busyO[0]);
                end
                lastResult = e.val;
            end else begin
                checks++;
                if (busyO[0] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL unmasked_busy cycle %0d got %b want 1", n, busyO[0]);
                end
                tick();
                n++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL unmasked_timeout got no done want done at %0d", L0 + 17);
        end
        tick();
    endtask

    task automatic test_stall();
        exp_t e; bit found; bit seen = 1'b0; bit expEn; int n = 1; int expDone;
        logic [63:0] s1 = {$urandom, $urandom};
        logic [63:0] s2 = {$urandom, $urandom};
        $display("[TB] test_stall");
`ifdef RND_STALL_EN
        begin
            int cnt = 0; int c = 0;
            while (cnt < L0 + 16) begin
                c++;
                if (pat(c)) cnt++;
            end
            expDone = c + 1;
        end
`else
        expDone = L0 + 17;
`endif
        rnd_vld = 1'b1;
        applyStimulus(64'h0123456789ABCDEF ^ s1 ^ s2, s1, s2, 3'b001, expDone - (L0 + 17));
        while (!seen && n <= 120) begin
            rnd_vld = pat(n);
            #1;
`ifdef RND_STALL_EN
            expEn = (n < expDone) && pat(n);
`else
            expEn = (n < expDone);
`endif
            checks++;
            if (sboxEn[0] !== expEn) begin
                errors++;
                $display("[TB] FAIL stall_en cycle %0d rnd_vld=%b got %b want %b", n, rnd_vld, sboxEn[0], expEn);
            end
            if (doneO[0] === 1'b1) begin
                seen = 1'b1;
                popFor(0, e, found);
                checks++;
                if (!found || n != e.doneCyc) begin
                    errors++;
                    $display("[TB] FAIL stall_latency got cycle %0d want %0d", n, expDone);
                end
                checks++;
                if (outXor(0) !== 64'hC56B90AD3EF84712) begin
                    errors++;
                    $display("[TB] FAIL stall_value got %h want C56B90AD3EF84712", outXor(0));
                end
                lastResult = 64'hC56B90AD3EF84712;
            end else begin
                tick();
                n++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL stall_timeout got no done want done at %0d", expDone);
        end
        rnd_vld = 1'b1;
        tick();
    endtask

    task automatic test_start_ignored();
        exp_t e; bit found; int doneCnt = 0;
        logic [63:0] plain = {$urandom, $urandom};
        logic [63:0] s1 = {$urandom, $urandom};
        logic [63:0] s2 = {$urandom, $urandom};
        logic [63:0] prev = lastResult;
        logic [63:0] want = sboxLayer(plain);
        $display("[TB] test_start_ignored");
        rnd_vld = 1'b1;
        applyStimulus(plain ^ s1 ^ s2, s1, s2, 3'b001, 0);
        for (int n = 1; n <= L0 + 23; n++) begin
            start = (n == 5) || (n == L0 + 17);
            #1;
            if (n < L0 + 17) begin
                checks++;
                if (outXor(0) !== prev) begin
                    errors++;
                    $display("[TB] FAIL hold_prev cycle %0d got %h want %h", n, outXor(0), prev);
                end
            end
            if (doneO[0] === 1'b1) begin
                doneCnt++;
                popFor(0, e, found);
                checks++;
                if (!found || n != e.doneCyc) begin
                    errors++;
                    $display("[TB] FAIL ignore_latency got cycle %0d want %0d", n, L0 + 17);
                end
            end
            if (n > L0 + 17) begin
                checks++;
                if (busyO[0] !== 1'b0 || outXor(0) !== want) begin
                    errors++;
                    $display("[TB] FAIL ignore_after cycle %0d got busy=%b val=%h want busy=0 val=%h", n, busyO[0], outXor(0), want);
                end
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (doneCnt != 1) begin
            errors++;
            $display("[TB] FAIL ignore_done_count got %0d want 1", doneCnt);
        end
        lastResult = want;
    endtask

    task automatic test_reset_mid();
        exp_t e; bit found; bit seen = 1'b0; int n = 1;
        logic [63:0] plain = {$urandom, $urandom};
        logic [63:0] s1 = {$urandom, $urandom};
        logic [63:0] s2 = {$urandom, $urandom};
        $display("[TB] test_reset_mid");
        rnd_vld = 1'b1;
        applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 3'b001, 0);
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) rst_n = 1'b0;
            tick();
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({busyO[0], sboxEn[0], doneO[0]} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midreset_ctrl got busy/en/done=%b want 000", {busyO[0], sboxEn[0], doneO[0]});
        end
        checks++;
        if ((shOut0[0] | shOut1[0] | shOut2[0]) !== 64'h0) begin
            errors++;
            $display("[TB] FAIL midreset_out got %h/%h/%h want 0", shOut0[0], shOut1[0], shOut2[0]);
        end
        sbq.delete();
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (doneO[0] !== 1'b0 || busyO[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet got done=%b busy=%b want 0 0", doneO[0], busyO[0]);
            end
            tick();
        end
        applyStimulus(plain ^ s1 ^ s2, s1, s2, 3'b001, 0);
        while (!seen && n <= 60) begin
            #1;
            if (doneO[0] === 1'b1) begin
                seen = 1'b1;
                popFor(0, e, found);
                checks++;
                if (!found || n != e.doneCyc) begin
                    errors++;
                    $display("[TB] FAIL midreset_restart_latency got cycle %0d want %0d", n, L0 + 17);
                end
                checks++;
                if (outXor(0) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL midreset_restart_value got %h want %h", outXor(0), e.val);
                end
                lastResult = e.val;
            end else begin
                tick();
                n++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL midreset_timeout got no done want done at %0d", L0 + 17);
        end
        tick();
    endtask

    task automatic test_no_stall();
`ifndef RND_STALL_EN
        exp_t e; bit found; bit seen = 1'b0; int n = 1;
        logic [63:0] s1 = {$urandom, $urandom};
        logic [63:0] s2 = {$urandom, $urandom};
        $display("[TB] test_no_stall");
        rnd_vld = 1'b0;
        applyStimulus(64'h0123456789ABCDEF ^ s1 ^ s2, s1, s2, 3'b001, 0);
        while (!seen && n <= 60) begin
            #1;
            checks++;
            if (sboxEn[0] !== (n < L0 + 17)) begin
                errors++;
                $display("[TB] FAIL nostall_en cycle %0d got %b want %b", n, sboxEn[0], (n < L0 + 17));
            end
            if (doneO[0] === 1'b1) begin
                seen = 1'b1;
                popFor(0, e, found);
                checks++;
                if (!found || n != e.doneCyc) begin
                    errors++;
                    $display("[TB] FAIL nostall_latency got cycle %0d want %0d", n, L0 + 17);
                end
                checks++;
                if (outXor(0) !== 64'hC56B90AD3EF84712) begin
                    errors++;
                    $display("[TB] FAIL nostall_value got %h want C56B90AD3EF84712", outXor(0));
                end
            end else begin
                tick();
                n++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL nostall_timeout got no done want done at %0d", L0 + 17);
        end
        rnd_vld = 1'b1;
        tick();
`else
        $display("[TB] test_no_stall skipped in the rnd_vld stall build");
`endif
    endtask

    task automatic test_lat_sweep();
        exp_t e; bit found;
        int doneCnt [NDUT];
        $display("[TB] test_lat_sweep");
        for (int d = 0; d < NDUT; d++) doneCnt[d] = 0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        rnd_vld = 1'b1;
        sbq.delete();
        applyStimulus(64'h0, 64'h0, 64'h0, 3'b111, 0);
        for (int n = 1; n <= 35; n++) begin
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (doneO[d] === 1'b1) begin
                    doneCnt[d]++;
                    popFor(d, e, found);
                    checks++;
                    if (!found || n != e.doneCyc) begin
                        errors++;
                        $display("[TB] FAIL sweep_latency LAT=%0d got cycle %0d want %0d", latOf(d), n, latOf(d) + 17);
                    end
                    checks++;
                    if (outXor(d) !== 64'hCCCCCCCCCCCCCCCC) begin
                        errors++;
                        $display("[TB] FAIL sweep_value LAT=%0d got %h want CCCCCCCCCCCCCCCC", latOf(d), outXor(d));
                    end
                end
            end
            tick();
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (doneCnt[d] != 1) begin
                errors++;
                $display("[TB] FAIL sweep_done_count LAT=%0d got %0d want 1", latOf(d), doneCnt[d]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rnd_vld = 1'b0;
        shIn0 = 64'h0; shIn1 = 64'h0; shIn2 = 64'h0;
        test_reset();
        test_unmasked();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_no_stall();
        test_lat_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got no finish want finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
